// File: rtl/typewriter_pkg.sv
// Shared widths and command codes for the typewriter-style keypad display.
package typewriter_pkg;

  localparam int KEY_W   = 5;
  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 8;

  localparam logic [KEY_W-1:0] KEY_BKSP = 5'd16;
  localparam logic [KEY_W-1:0] KEY_CLR  = 5'd17;

  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return (code < KEY_BKSP);
  endfunction

endpackage

// File: rtl/segment.sv
// Hex digit to 7-segment decoder, active-low {dp,g,f,e,d,c,b,a}; dp always off.
module segment
  import typewriter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   segs_o
);

  logic [6:0] pat;

  always_comb begin
    pat = 7'h00;
    case (digit_i)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  assign segs_o = {1'b1, ~pat};

endmodule

// File: rtl/scroll_display.sv
// N-slot typewriter display: digits fill left to right, then scroll or are rejected when full.
// Backspace and clear edit the buffer; one action per key press, acted on with 1-cycle latency.
module scroll_display
  import typewriter_pkg::*;
#(
  parameter int              NUM_DIGITS = 4,
  parameter bit              SCROLL_EN  = 1'b1,
  parameter logic [SEG_W-1:0] BLANK_SEGS = 8'hFF,
  localparam int             CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        key_pressed,
  output logic [SEG_W*NUM_DIGITS-1:0] segs_out,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic                        key_accept,
  output logic                        overflow
);

  logic [DIGIT_W-1:0] digit_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] digit_d [NUM_DIGITS];
  logic               valid_q [NUM_DIGITS];
  logic               valid_d [NUM_DIGITS];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               prev_q;
  logic               accept_q, accept_d;
  logic               ovf_q, ovf_d;
  logic               press;

  assign press = key_pressed & ~prev_q;

  always_comb begin
    digit_d  = digit_q;
    valid_d  = valid_q;
    count_d  = count_q;
    accept_d = 1'b0;
    ovf_d    = 1'b0;
    if (press) begin
      if (is_digit(key_code)) begin
        if (count_q < CNT_W'(NUM_DIGITS)) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) == count_q) begin
              digit_d[i] = key_code[DIGIT_W-1:0];
              valid_d[i] = 1'b1;
            end
          end
          count_d  = count_q + CNT_W'(1);
          accept_d = 1'b1;
        end else if (SCROLL_EN) begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            digit_d[i] = digit_q[i+1];
            valid_d[i] = valid_q[i+1];
          end
          digit_d[NUM_DIGITS-1] = key_code[DIGIT_W-1:0];
          valid_d[NUM_DIGITS-1] = 1'b1;
          accept_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (key_code == KEY_BKSP) begin
        if (count_q != '0) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) == count_q - CNT_W'(1)) begin
              digit_d[i] = '0;
              valid_d[i] = 1'b0;
            end
          end
          count_d  = count_q - CNT_W'(1);
          accept_d = 1'b1;
        end
      end else if (key_code == KEY_CLR) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          digit_d[i] = '0;
          valid_d[i] = 1'b0;
        end
        count_d  = '0;
        accept_d = 1'b1;
      end
    end
  end

  // prev_q resets high so a key held through reset needs a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
        valid_q[i] <= 1'b0;
      end
      count_q  <= '0;
      prev_q   <= 1'b1;
      accept_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      prev_q   <= key_pressed;
      accept_q <= accept_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    logic [SEG_W-1:0] dec_segs;
    segment u_segment (
      .digit_i (digit_q[g]),
      .segs_o  (dec_segs)
    );
    assign segs_out[SEG_W*g +: SEG_W] = valid_q[g] ? dec_segs : BLANK_SEGS;
  end

  assign count      = count_q;
  assign full       = (count_q == CNT_W'(NUM_DIGITS));
  assign empty      = (count_q == '0);
  assign key_accept = accept_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_scroll_display.sv
// Three configurations (N=4 scroll, N=4 reject, N=6 scroll) share one key stream and
// are checked against queue-based reference models.
module tb_scroll_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic        key_pressed = 1'b0;

  logic [31:0] segs4, segsr;
  logic [47:0] segs6;
  logic [2:0]  cnt4, cntr, cnt6;
  logic        full4, fullr, full6, emp4, empr, emp6;
  logic        acc4, accr, acc6, ovf4, ovfr, ovf6;

  int checks = 0;
  int errors = 0;
  int mq [3][$];
  bit exp_acc [3];
  bit exp_ovf [3];

  always #5 clk = ~clk;

  scroll_display #(.NUM_DIGITS(4), .SCROLL_EN(1'b1), .BLANK_SEGS(8'hFF)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_pressed(key_pressed),
    .segs_out(segs4), .count(cnt4), .full(full4), .empty(emp4),
    .key_accept(acc4), .overflow(ovf4));

  scroll_display #(.NUM_DIGITS(4), .SCROLL_EN(1'b0), .BLANK_SEGS(8'hFF)) u_dutr (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_pressed(key_pressed),
    .segs_out(segsr), .count(cntr), .full(fullr), .empty(empr),
    .key_accept(accr), .overflow(ovfr));

  scroll_display #(.NUM_DIGITS(6), .SCROLL_EN(1'b1), .BLANK_SEGS(8'hFF)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_pressed(key_pressed),
    .segs_out(segs6), .count(cnt6), .full(full6), .empty(emp6),
    .key_accept(acc6), .overflow(ovf6));

  function automatic int slots_of(int k);
    return (k == 2) ? 6 : 4;
  endfunction

  function automatic bit scrolls(int k);
    return (k != 1);
  endfunction

  // Reference 7-segment pattern, active-low with dp off
  function automatic logic [7:0] seg_of(int d);
    logic [6:0] p;
    case (d)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
      4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
      8: p = 7'h7F;  9: p = 7'h6F; 10: p = 7'h77; 11: p = 7'h7C;
      12: p = 7'h39; 13: p = 7'h5E; 14: p = 7'h79; default: p = 7'h71;
    endcase
    return {1'b1, ~p};
  endfunction

  function automatic void model_press(int c);
    for (int k = 0; k < 3; k++) begin
      exp_acc[k] = 1'b0;
      exp_ovf[k] = 1'b0;
      if (c < 16) begin
        if (mq[k].size() < slots_of(k)) begin
          mq[k].push_back(c);
          exp_acc[k] = 1'b1;
        end else if (scrolls(k)) begin
          void'(mq[k].pop_front());
          mq[k].push_back(c);
          exp_acc[k] = 1'b1;
        end else begin
          exp_ovf[k] = 1'b1;
        end
      end else if (c == 16) begin
        if (mq[k].size() > 0) begin
          void'(mq[k].pop_back());
          exp_acc[k] = 1'b1;
        end
      end else if (c == 17) begin
        mq[k].delete();
        exp_acc[k] = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input bit quiet);
    logic [47:0] ea, eo;
    ea = '0;
    eo = '0;
    if (!quiet) begin
      ea[2:0] = {exp_acc[2], exp_acc[1], exp_acc[0]};
      eo[2:0] = {exp_ovf[2], exp_ovf[1], exp_ovf[0]};
    end
    chk({tag, ".accept"}, {45'd0, acc6, accr, acc4}, ea);
    chk({tag, ".overflow"}, {45'd0, ovf6, ovfr, ovf4}, eo);
  endtask

  task automatic check_state(input string tag);
    logic [47:0] act_segs, exp_segs;
    int act_cnt, n, sz;
    bit act_full, act_emp;
    for (int k = 0; k < 3; k++) begin
      n = slots_of(k);
      sz = mq[k].size();
      case (k)
        0: begin act_segs = {16'h0, segs4}; act_cnt = cnt4; act_full = full4; act_emp = emp4; end
        1: begin act_segs = {16'h0, segsr}; act_cnt = cntr; act_full = fullr; act_emp = empr; end
        default: begin act_segs = segs6; act_cnt = cnt6; act_full = full6; act_emp = emp6; end
      endcase
      exp_segs = '0;
      for (int i = 0; i < n; i++)
        exp_segs[8*i +: 8] = (i < sz) ? seg_of(mq[k][i]) : 8'hFF;
      chk($sformatf("%s.segs[%0d]", tag, k), act_segs, exp_segs);
      chk($sformatf("%s.count[%0d]", tag, k), 48'(act_cnt), 48'(sz));
      chk($sformatf("%s.full[%0d]", tag, k), 48'(act_full), 48'(sz == n));
      chk($sformatf("%s.empty[%0d]", tag, k), 48'(act_emp), 48'(sz == 0));
    end
  endtask

  task automatic press(input string tag, input int c, input int hold);
    @(negedge clk);
    key_code = 5'(c);
    key_pressed = 1'b1;
    model_press(c);
    @(posedge clk);
    #1;
    check_pulses(tag, 1'b0);
    check_state(tag);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_pulses({tag, ".hold"}, 1'b1);
    end
    @(negedge clk);
    key_pressed = 1'b0;
    @(posedge clk);
    #1;
    check_pulses({tag, ".rel"}, 1'b1);
    check_state({tag, ".rel"});
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_pulses("reset", 1'b1);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fill, then scroll / reject
    for (int d = 1; d <= 4; d++) press($sformatf("fill%0d", d), d, 1);
    press("over5", 5, 1);

    // Long hold yields one action
    press("hold7", 7, 20);

    // Backspace behaviour from a cleared buffer
    press("clr0", 17, 1);
    press("d9", 9, 1);
    press("d8", 8, 1);
    press("bksp1", 16, 1);
    press("bksp2", 16, 1);
    press("bksp3", 16, 2);

    // Clear, clear-when-empty, ignored codes
    press("a3", 10, 1);
    press("b3", 11, 1);
    press("c3", 12, 1);
    press("clr3", 17, 1);
    press("clr_empty", 17, 1);
    press("ign25", 25, 1);
    press("ign18", 18, 3);

    // Reset mid-scroll with key held
    for (int d = 0; d < 5; d++) press($sformatf("pre%0d", d), d + 2, 1);
    @(negedge clk);
    key_code = 5'd6;
    key_pressed = 1'b1;
    model_press(6);
    @(posedge clk);
    #1;
    check_pulses("scroll_before_rst", 1'b0);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) mq[k].delete();
    #1;
    check_pulses("async_rst", 1'b1);
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_pulses("held_after_rst", 1'b1);
    end
    check_state("held_after_rst");
    @(negedge clk);
    key_pressed = 1'b0;
    press("after_rst", 4, 1);

    // Eight digits into the six-slot display
    press("clr8", 17, 1);
    for (int d = 0; d < 8; d++) press($sformatf("eight%0d", d), 8 + d, 1);

    // Randomised key stream biased toward digits
    for (int r = 0; r < 150; r++) begin
      int c;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       c = int'($urandom_range(0, 15));
      else if (sel < 8)  c = 16;
      else if (sel == 8) c = 17;
      else               c = int'($urandom_range(18, 31));
      press($sformatf("rnd%0d", r), c, int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
